// File: rtl/btb_pkg.sv
// Shared types and helpers for the direct-mapped branch target buffer.
// Entry layout, counter encodings and the PC index/tag split.
package btb_pkg;

   // Widest index (ENTRIES=1024) and widest tag (ENTRIES=2) the BTB supports.
   localparam int IDX_W_MAX = 10;
   localparam int TAG_W_MAX = 29;

   // 2-bit saturating counter encodings.
   localparam logic [1:0] CTR_WEAK_TAKEN = 2'd2;
   localparam logic [1:0] CTR_MAX        = 2'd3;
   localparam logic [1:0] CTR_MIN        = 2'd0;

   // One BTB entry; tags narrower than TAG_W_MAX are stored zero-extended.
   typedef struct packed {
      logic                 valid;
      logic [TAG_W_MAX-1:0] tag;
      logic [31:0]          target;
      logic [1:0]           ctr;
   } btb_entry_t;

   // Result of splitting a PC into its index and tag fields.
   typedef struct packed {
      logic [IDX_W_MAX-1:0] idx;
      logic [TAG_W_MAX-1:0] tag;
   } addr_split_t;

   // Split a PC: index = addr[idx_bits+1:2], tag = addr[31:idx_bits+2].
   // Bits [1:0] never reach either field.
   function automatic addr_split_t btb_split_addr(input logic [31:0] addr,
                                                  input int          idx_bits);
      addr_split_t split;
      logic [31:0] word;
      logic [31:0] mask;
      word      = addr >> 2;
      mask      = (32'd1 << idx_bits) - 32'd1;
      split.idx = IDX_W_MAX'(word & mask);
      split.tag = TAG_W_MAX'(word >> idx_bits);
      return split;
   endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// Combinational 2-bit saturating up/down counter step.
// Used by the BTB only when BTB_2BIT_COUNTER_EN is defined.
module btb_sat_counter
   import btb_pkg::*;
(
   input  logic [1:0] ctr_in,
   input  logic       inc,
   output logic [1:0] ctr_out
);

   // Step the counter one position toward taken (inc=1) or not-taken, clamped at both ends.
   always_comb begin
      ctr_out = ctr_in;
      if (inc) begin
         if (ctr_in == CTR_MAX) begin
            ctr_out = ctr_in;
         end else begin
            ctr_out = ctr_in + 2'd1;
         end
      end else begin
         if (ctr_in == CTR_MIN) begin
            ctr_out = ctr_in;
         end else begin
            ctr_out = ctr_in - 2'd1;
         end
      end
   end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with a one-cycle registered lookup
// and a separate execute-stage training port.
// Optional feature macro: BTB_2BIT_COUNTER_EN (2-bit direction counters).
// Without it, a taken update allocates and a not-taken hit invalidates.
module branch_target_buffer #(
   parameter int ENTRIES = 16
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        STALL,
   input  logic [31:0] Instr_Addr_IN,
   input  logic        Update_IN,
   input  logic [31:0] Update_PC_IN,
   input  logic [31:0] Update_Target_IN,
   input  logic        Update_Taken_IN,
   output logic        Hit_OUT,
   output logic        Pred_Taken_OUT,
   output logic [31:0] Pred_Target_OUT
);
   import btb_pkg::*;

   localparam int IDX_BITS = $clog2(ENTRIES);
   localparam int TAG_BITS = 30 - IDX_BITS;
   localparam logic [31:0] TAG_MASK = (32'd1 << TAG_BITS) - 32'd1;

   btb_entry_t mem_r [ENTRIES];

   addr_split_t          lk_split_s;
   addr_split_t          up_split_s;
   logic [IDX_BITS-1:0]  lk_idx_s;
   logic [IDX_BITS-1:0]  up_idx_s;
   logic [TAG_W_MAX-1:0] lk_tag_s;
   logic [TAG_W_MAX-1:0] up_tag_s;
   logic                 unused_split_s;

   btb_entry_t           lk_entry_s;
   logic                 lk_hit_s;
   logic                 lk_taken_s;
   logic [31:0]          lk_target_s;

   btb_entry_t           up_entry_s;
   logic                 up_hit_s;
   btb_entry_t           upd_entry_s;
   logic                 upd_we_s;
   logic [1:0]           ctr_next_s;

   assign lk_split_s = btb_split_addr(Instr_Addr_IN, IDX_BITS);
   assign up_split_s = btb_split_addr(Update_PC_IN, IDX_BITS);
   assign lk_idx_s   = lk_split_s.idx[IDX_BITS-1:0];
   assign up_idx_s   = up_split_s.idx[IDX_BITS-1:0];
   assign lk_tag_s   = lk_split_s.tag & TAG_MASK[TAG_W_MAX-1:0];
   assign up_tag_s   = up_split_s.tag & TAG_MASK[TAG_W_MAX-1:0];
   // Upper index bits beyond IDX_BITS are always zero and intentionally dropped.
   assign unused_split_s = ^{lk_split_s, up_split_s};

`ifdef BTB_2BIT_COUNTER_EN
   btb_sat_counter u_sat_counter (
      .ctr_in  (up_entry_s.ctr),
      .inc     (Update_Taken_IN),
      .ctr_out (ctr_next_s)
   );
`else
   assign ctr_next_s = 2'd0;
`endif

   // Lookup side: read the pre-update entry and form the prediction.
   always_comb begin
      lk_entry_s  = mem_r[lk_idx_s];
      lk_hit_s    = lk_entry_s.valid && (lk_entry_s.tag == lk_tag_s);
`ifdef BTB_2BIT_COUNTER_EN
      lk_taken_s  = lk_hit_s & lk_entry_s.ctr[1];
`else
      lk_taken_s  = lk_hit_s;
`endif
      if (lk_hit_s) begin
         lk_target_s = lk_entry_s.target;
      end else begin
         lk_target_s = 32'd0;
      end
   end

   // Update side: decide whether and how the indexed entry is rewritten.
   always_comb begin
      up_entry_s  = mem_r[up_idx_s];
      up_hit_s    = up_entry_s.valid && (up_entry_s.tag == up_tag_s);
      upd_entry_s = up_entry_s;
      upd_we_s    = 1'b0;
      if (Update_Taken_IN) begin
         upd_we_s           = 1'b1;
         upd_entry_s.target = Update_Target_IN;
`ifdef BTB_2BIT_COUNTER_EN
         if (up_hit_s) begin
            upd_entry_s.ctr = ctr_next_s;
         end else begin
            upd_entry_s.valid = 1'b1;
            upd_entry_s.tag   = up_tag_s;
            upd_entry_s.ctr   = CTR_WEAK_TAKEN;
         end
`else
         upd_entry_s.valid = 1'b1;
         upd_entry_s.tag   = up_tag_s;
         upd_entry_s.ctr   = ctr_next_s;
`endif
      end else if (up_hit_s) begin
         upd_we_s = 1'b1;
`ifdef BTB_2BIT_COUNTER_EN
         upd_entry_s.ctr = ctr_next_s;
`else
         upd_entry_s.valid = 1'b0;
`endif
      end else begin
         // Not-taken update of a different or empty entry: leave it alone.
         upd_we_s = 1'b0;
      end
   end

   // Storage write, valid-bit reset and registered lookup outputs with stall hold.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         for (int i = 0; i < ENTRIES; i++) begin
            mem_r[i].valid <= 1'b0;
         end
         Hit_OUT         <= 1'b0;
         Pred_Taken_OUT  <= 1'b0;
         Pred_Target_OUT <= 32'd0;
      end else begin
         if (Update_IN && upd_we_s) begin
            mem_r[up_idx_s] <= upd_entry_s;
         end
         if (!STALL) begin
            Hit_OUT         <= lk_hit_s;
            Pred_Taken_OUT  <= lk_taken_s;
            Pred_Target_OUT <= lk_target_s;
         end
      end
   end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer (ENTRIES=16).
module tb_branch_target_buffer;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        STALL;
   logic [31:0] Instr_Addr_IN;
   logic        Update_IN;
   logic [31:0] Update_PC_IN;
   logic [31:0] Update_Target_IN;
   logic        Update_Taken_IN;
   logic        Hit_OUT;
   logic        Pred_Taken_OUT;
   logic [31:0] Pred_Target_OUT;

   int errors = 0;
   int checks = 0;

   branch_target_buffer #(.ENTRIES(16)) dut (
      .CLK              (CLK),
      .RESET            (RESET),
      .STALL            (STALL),
      .Instr_Addr_IN    (Instr_Addr_IN),
      .Update_IN        (Update_IN),
      .Update_PC_IN     (Update_PC_IN),
      .Update_Target_IN (Update_Target_IN),
      .Update_Taken_IN  (Update_Taken_IN),
      .Hit_OUT          (Hit_OUT),
      .Pred_Taken_OUT   (Pred_Taken_OUT),
      .Pred_Target_OUT  (Pred_Target_OUT)
   );

   always #5 CLK = ~CLK;

   // Advance one clock and settle 1 time unit past the edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // One-cycle update pulse (lookup input unchanged).
   task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
      Update_IN = 1'b1; Update_PC_IN = pc; Update_Target_IN = tgt; Update_Taken_IN = taken;
      tick();
      Update_IN = 1'b0;
   endtask

   // Present a lookup PC for one edge; outputs then reflect it.
   task automatic do_lookup(input logic [31:0] pc);
      Instr_Addr_IN = pc;
      tick();
   endtask

   task automatic test_reset();
      RESET = 1'b0; STALL = 1'b0; Instr_Addr_IN = 32'h0040_0010;
      Update_IN = 1'b1; Update_PC_IN = 32'h0040_0010;
      Update_Target_IN = 32'h0040_0100; Update_Taken_IN = 1'b1;
      tick(); tick();
      checks++; if (Hit_OUT !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", Hit_OUT); end
      checks++; if (Pred_Taken_OUT !== 1'b0) begin errors++; $display("FAIL reset_taken: got %b want 0", Pred_Taken_OUT); end
      checks++; if (Pred_Target_OUT !== 32'd0) begin errors++; $display("FAIL reset_target: got %h want 0", Pred_Target_OUT); end
      RESET = 1'b1; Update_IN = 1'b0;
      do_lookup(32'h0040_0010);
      checks++; if (Hit_OUT !== 1'b0) begin errors++; $display("FAIL reset_update_dropped_hit: got %b want 0", Hit_OUT); end
      checks++; if (Pred_Target_OUT !== 32'd0) begin errors++; $display("FAIL reset_update_dropped_target: got %h want 0", Pred_Target_OUT); end
   endtask

   task automatic test_basic_hit();
      Instr_Addr_IN = 32'h0000_0000;
      do_update(32'h0040_0010, 32'h0040_0100, 1'b1);
      do_lookup(32'h0040_0010);
      checks++; if (Hit_OUT !== 1'b1) begin errors++; $display("FAIL basic_hit: got %b want 1", Hit_OUT); end
      checks++; if (Pred_Taken_OUT !== 1'b1) begin errors++; $display("FAIL basic_taken: got %b want 1", Pred_Taken_OUT); end
      checks++; if (Pred_Target_OUT !== 32'h0040_0100) begin errors++; $display("FAIL basic_target: got %h want 00400100", Pred_Target_OUT); end
      do_lookup(32'h0040_0013);
      checks++; if (Hit_OUT !== 1'b1) begin errors++; $display("FAIL low_bits_ignored: got %b want 1", Hit_OUT); end
   endtask

   task automatic test_alias();
      do_update(32'h0040_0050, 32'h0040_0200, 1'b1);
      do_lookup(32'h0040_0010);
      checks++; if (Hit_OUT !== 1'b0) begin errors++; $display("FAIL alias_old_hit: got %b want 0", Hit_OUT); end
      checks++; if (Pred_Target_OUT !== 32'd0) begin errors++; $display("FAIL alias_old_target: got %h want 0", Pred_Target_OUT); end
      do_lookup(32'h0040_0050);
      checks++; if (Hit_OUT !== 1'b1) begin errors++; $display("FAIL alias_new_hit: got %b want 1", Hit_OUT); end
      checks++; if (Pred_Target_OUT !== 32'h0040_0200) begin errors++; $display("FAIL alias_new_target: got %h want 00400200", Pred_Target_OUT); end
      // Not-taken update with a different tag leaves the resident entry alone.
      do_update(32'h0040_0010, 32'h0040_0999, 1'b0);
      do_lookup(32'h0040_0050);
      checks++; if (Pred_Target_OUT !== 32'h0040_0200) begin errors++; $display("FAIL nt_mismatch_kept: got %h want 00400200", Pred_Target_OUT); end
      do_update(32'h0040_0010, 32'h0040_0100, 1'b1);
   endtask

   task automatic test_stall();
      do_lookup(32'h0040_0010);
      checks++; if (Hit_OUT !== 1'b1) begin errors++; $display("FAIL stall_pre_hit: got %b want 1", Hit_OUT); end
      STALL = 1'b1; Instr_Addr_IN = 32'h0040_0080;
      do_update(32'h0040_0030, 32'h0040_0300, 1'b1);
      for (int k = 0; k < 2; k++) begin
         checks++; if (Hit_OUT !== 1'b1) begin errors++; $display("FAIL stall_hold_hit[%0d]: got %b want 1", k, Hit_OUT); end
         checks++; if (Pred_Target_OUT !== 32'h0040_0100) begin errors++; $display("FAIL stall_hold_target[%0d]: got %h want 00400100", k, Pred_Target_OUT); end
         tick();
      end
      STALL = 1'b0;
      tick();
      checks++; if (Hit_OUT !== 1'b0) begin errors++; $display("FAIL stall_release_hit: got %b want 0", Hit_OUT); end
      checks++; if (Pred_Target_OUT !== 32'd0) begin errors++; $display("FAIL stall_release_target: got %h want 0", Pred_Target_OUT); end
      do_lookup(32'h0040_0030);
      checks++; if (Pred_Target_OUT !== 32'h0040_0300) begin errors++; $display("FAIL update_during_stall: got %h want 00400300", Pred_Target_OUT); end
   endtask

   task automatic test_same_cycle();
      Instr_Addr_IN = 32'h0040_0020;
      do_update(32'h0040_0020, 32'h0040_0400, 1'b1);
      checks++; if (Hit_OUT !== 1'b0) begin errors++; $display("FAIL same_cycle_old: got %b want 0", Hit_OUT); end
      tick();
      checks++; if (Hit_OUT !== 1'b1) begin errors++; $display("FAIL same_cycle_next_hit: got %b want 1", Hit_OUT); end
      checks++; if (Pred_Target_OUT !== 32'h0040_0400) begin errors++; $display("FAIL same_cycle_next_target: got %h want 00400400", Pred_Target_OUT); end
   endtask

`ifdef BTB_2BIT_COUNTER_EN
   task automatic test_counter();
      do_update(32'h0040_0024, 32'h0040_0500, 1'b1);
      do_lookup(32'h0040_0024);
      checks++; if (Pred_Taken_OUT !== 1'b1) begin errors++; $display("FAIL ctr_alloc_taken: got %b want 1", Pred_Taken_OUT); end
      do_update(32'h0040_0024, 32'h0040_0500, 1'b0);
      do_update(32'h0040_0024, 32'h0040_0500, 1'b0);
      do_update(32'h0040_0024, 32'h0040_0500, 1'b0);
      do_lookup(32'h0040_0024);
      checks++; if (Hit_OUT !== 1'b1) begin errors++; $display("FAIL ctr_low_hit: got %b want 1", Hit_OUT); end
      checks++; if (Pred_Taken_OUT !== 1'b0) begin errors++; $display("FAIL ctr_low_taken: got %b want 0", Pred_Taken_OUT); end
      do_update(32'h0040_0024, 32'h0040_0500, 1'b1);
      do_lookup(32'h0040_0024);
      checks++; if (Pred_Taken_OUT !== 1'b0) begin errors++; $display("FAIL ctr_one_taken: got %b want 0", Pred_Taken_OUT); end
      do_update(32'h0040_0024, 32'h0040_0600, 1'b1);
      do_lookup(32'h0040_0024);
      checks++; if (Pred_Taken_OUT !== 1'b1) begin errors++; $display("FAIL ctr_two_taken: got %b want 1", Pred_Taken_OUT); end
      checks++; if (Pred_Target_OUT !== 32'h0040_0600) begin errors++; $display("FAIL ctr_target_rewrite: got %h want 00400600", Pred_Target_OUT); end
      do_update(32'h0040_0024, 32'h0040_0600, 1'b1);
      do_update(32'h0040_0024, 32'h0040_0600, 1'b1);
      do_update(32'h0040_0024, 32'h0040_0600, 1'b0);
      do_lookup(32'h0040_0024);
      checks++; if (Pred_Taken_OUT !== 1'b1) begin errors++; $display("FAIL ctr_saturate_high: got %b want 1", Pred_Taken_OUT); end
   endtask
`else
   task automatic test_not_taken_invalidate();
      do_update(32'h0040_0020, 32'h0040_0400, 1'b0);
      do_lookup(32'h0040_0020);
      checks++; if (Hit_OUT !== 1'b0) begin errors++; $display("FAIL nt_invalidate_hit: got %b want 0", Hit_OUT); end
      checks++; if (Pred_Taken_OUT !== 1'b0) begin errors++; $display("FAIL nt_invalidate_taken: got %b want 0", Pred_Taken_OUT); end
   endtask
`endif

   initial begin
      RESET = 1'b0; STALL = 1'b0; Instr_Addr_IN = 32'd0; Update_IN = 1'b0;
      Update_PC_IN = 32'd0; Update_Target_IN = 32'd0; Update_Taken_IN = 1'b0;
      test_reset();
      test_basic_hit();
      test_alias();
      test_stall();
      test_same_cycle();
`ifdef BTB_2BIT_COUNTER_EN
      test_counter();
`else
      test_not_taken_invalidate();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
